spectrum_frame_engine: RTL and testbench

Parametrised frame controller between the audio sample stream and an external AXI-Stream FFT core. It captures one frame of N = 2^LOG2_N signed samples, using either an optional rising zero-crossing trigger or auto-trigger. It streams the frame into the FFT with correct `tlast` framing, converts each returned complex bin to a scaled, saturated 8-bit power value, and optionally applies peak-hold or 2:1 averaging across frames before presenting bins to the display path.

---
 rtl/spectrum_pkg.sv | 24 ++
 rtl/spectrum_power_pipe.sv | 101 ++++++++++
 rtl/spectrum_frame_engine.sv | 170 +++++++++++++++++
 tb/tb_spectrum_frame_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared types and width helpers for the spectrum frame engine.
package spectrum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_LOAD,
    ST_UNLOAD
  } state_t;

  localparam logic [1:0] AVG_BYPASS = 2'b00;
  localparam logic [1:0] AVG_PEAK   = 2'b01;
  localparam logic [1:0] AVG_MEAN   = 2'b10;

  function automatic int power_w(input int fft_w);
    return 2 * fft_w - 1;
  endfunction

  function automatic int window_lsb(input int fft_w, input int sel);
    return power_w(fft_w) - 8 - sel;
  endfunction

endpackage

// File: rtl/spectrum_power_pipe.sv
// Three-stage bin pipeline: register, power/scale/saturate with hold read,
// then peak/average combine with hold write-back.
module spectrum_power_pipe
  import spectrum_pkg::*;
#(
  parameter int LOG2_N = 10,
  parameter int FFT_W  = 18
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  input  logic [FFT_W-1:0]  in_re,
  input  logic [FFT_W-1:0]  in_im,
  input  logic [LOG2_N-1:0] in_k,
  input  logic [2:0]        scale_sel,
  input  logic [1:0]        avg_mode,
  input  logic              clear_hold,
  output logic              freq_valid,
  output logic [LOG2_N-1:0] freq_addr,
  output logic [7:0]        freq_byte,
  output logic              frame_done
);

  localparam int N = 1 << LOG2_N;

  logic                     v0, v1;
  logic signed [FFT_W-1:0]  re0, im0;
  logic [LOG2_N-1:0]        k0, k1;
  logic                     last1;
  logic [7:0]               raw1, hold_q;
  logic [7:0]               hold_mem [N];
  logic                     hold_valid;
  logic [1:0]               mode_q;

  // One extra bit above the nominal power width absorbs the both-components-at-minimum corner
  logic signed [2*FFT_W-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*FFT_W-1:0]        pwr, shifted;
  logic [7:0]                raw_d, cmb, out_d;
  logic [8:0]                sum9;

  assign re_x    = {{FFT_W{re0[FFT_W-1]}}, re0};
  assign im_x    = {{FFT_W{im0[FFT_W-1]}}, im0};
  assign re_sq   = re_x * re_x;
  assign im_sq   = im_x * im_x;
  assign pwr     = $unsigned(re_sq) + $unsigned(im_sq);
  assign shifted = pwr >> window_lsb(FFT_W, int'(scale_sel));
  assign raw_d   = (|shifted[2*FFT_W-1:8]) ? 8'hFF : shifted[7:0];

  assign sum9 = {1'b0, raw1} + {1'b0, hold_q} + 9'd1;

  always_comb begin
    cmb = raw1;
    case (avg_mode)
      AVG_PEAK: cmb = (raw1 > hold_q) ? raw1 : hold_q;
      AVG_MEAN: cmb = sum9[8:1];
      default:  cmb = raw1;
    endcase
    out_d = hold_valid ? cmb : raw1;
  end

  always_ff @(posedge aclk) begin
    if (in_valid) begin
      re0 <= in_re;
      im0 <= in_im;
      k0  <= in_k;
    end
    raw1   <= raw_d;
    k1     <= k0;
    last1  <= (k0 == '1);
    hold_q <= hold_mem[k0];
    mode_q <= avg_mode;
    if (v1)
      hold_mem[k1] <= out_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      freq_valid <= 1'b0;
      freq_addr  <= '0;
      freq_byte  <= '0;
      frame_done <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      v0         <= in_valid;
      v1         <= v0;
      freq_valid <= v1;
      frame_done <= v1 && last1;
      if (v1) begin
        freq_addr <= k1;
        freq_byte <= out_d;
      end
      if (clear_hold || (avg_mode != mode_q))
        hold_valid <= 1'b0;
      else if (v1 && last1)
        hold_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/spectrum_frame_engine.sv
// Frame controller: trigger/capture into a time buffer, stream to the FFT,
// and hand returned bins to the power pipeline.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_ARM     | watching samples for a trigger (or auto-trigger)
//   ST_CAPTURE | writing samples 1..N-1 into the time buffer
//   ST_LOAD    | streaming the buffer to the FFT input
//   ST_UNLOAD  | accepting FFT bins until the pipeline drains
module spectrum_frame_engine
  import spectrum_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LOG2_N   = 10,
  parameter int FFT_W    = 18
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  trig_mode,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_data,
  input  logic [2:0]            scale_sel,
  input  logic [1:0]            avg_mode,
  input  logic                  clear_hold,
  output logic [2*SAMPLE_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [2*FFT_W-1:0]    s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  freq_valid,
  output logic [LOG2_N-1:0]     freq_addr,
  output logic [7:0]            freq_byte,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_tlast
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N:0] AUTO_N = (LOG2_N+1)'(N);

  state_t state, state_nxt;

  logic [SAMPLE_W-1:0] prev;
  logic [LOG2_N:0]     auto_cnt;
  logic [LOG2_N-1:0]   wr_addr, wr_idx, beat, rd_addr, bin_k;
  logic                load_vld, bins_all, err_q;
  logic                trig, wr_en, m_fire, s_fire;
  logic [SAMPLE_W-1:0] tbuf [N];
  logic [SAMPLE_W-1:0] ram_q;

  assign trig   = sample_valid &&
                  (!trig_mode || (prev[SAMPLE_W-1] && !sample_data[SAMPLE_W-1]) ||
                   (auto_cnt == AUTO_N));
  assign m_fire = load_vld && m_axis_tready;
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign wr_en  = ((state == ST_ARM) && trig) || ((state == ST_CAPTURE) && sample_valid);
  assign wr_idx = (state == ST_ARM) ? '0 : wr_addr;
  // Read one ahead on a handshake so the RAM output always matches the current beat
  assign rd_addr = m_fire ? beat + 1'b1 : beat;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_ARM;
      ST_ARM:     if (trig) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (sample_valid && (wr_addr == '1)) state_nxt = ST_LOAD;
      ST_LOAD:    if (m_fire && (beat == '1)) state_nxt = ST_UNLOAD;
      ST_UNLOAD:  if (frame_done) state_nxt = continuous ? ST_ARM : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (wr_en)
      tbuf[wr_idx] <= sample_data;
    ram_q <= tbuf[rd_addr];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prev     <= '0;
      auto_cnt <= '0;
      wr_addr  <= '0;
      beat     <= '0;
      load_vld <= 1'b0;
      bin_k    <= '0;
      bins_all <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_q    <= 1'b0;
            auto_cnt <= '0;
          end
        end
        ST_ARM: begin
          if (sample_valid) begin
            prev <= sample_data;
            if (trig)
              wr_addr <= LOG2_N'(1);
            else
              auto_cnt <= auto_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid)
            wr_addr <= wr_addr + 1'b1;
        end
        ST_LOAD: begin
          if (m_fire)
            beat <= beat + 1'b1;
          load_vld <= !(m_fire && (beat == '1));
        end
        ST_UNLOAD: begin
          if (s_fire) begin
            bin_k <= bin_k + 1'b1;
            if (bin_k == '1)
              bins_all <= 1'b1;
            if (s_axis_tlast != (bin_k == '1))
              err_q <= 1'b1;
          end
          if (frame_done) begin
            bins_all <= 1'b0;
            auto_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = load_vld;
  assign m_axis_tdata  = load_vld ? {{SAMPLE_W{1'b0}}, ram_q} : '0;
  assign m_axis_tlast  = load_vld && (beat == '1);
  assign s_axis_tready = (state == ST_UNLOAD) && !bins_all;
  assign busy          = (state != ST_IDLE);
  assign err_tlast     = err_q;

  spectrum_power_pipe #(
    .LOG2_N (LOG2_N),
    .FFT_W  (FFT_W)
  ) u_power_pipe (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_valid   (s_fire),
    .in_re      (s_axis_tdata[FFT_W-1:0]),
    .in_im      (s_axis_tdata[2*FFT_W-1:FFT_W]),
    .in_k       (bin_k),
    .scale_sel  (scale_sel),
    .avg_mode   (avg_mode),
    .clear_hold (clear_hold),
    .freq_valid (freq_valid),
    .freq_addr  (freq_addr),
    .freq_byte  (freq_byte),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_spectrum_frame_engine.sv
// Directed bench for spectrum_frame_engine with N=16 and a simple FFT sink/source model.
module tb_spectrum_frame_engine;

  localparam int SW = 8;
  localparam int LN = 4;
  localparam int FW = 18;
  localparam int N  = 16;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic            aresetn, start, continuous, trig_mode, sample_valid, clear_hold;
  logic [SW-1:0]   sample_data;
  logic [2:0]      scale_sel;
  logic [1:0]      avg_mode;
  logic [2*SW-1:0] m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [2*FW-1:0] s_axis_tdata;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic            freq_valid, busy, frame_done, err_tlast;
  logic [LN-1:0]   freq_addr;
  logic [7:0]      freq_byte;

  spectrum_frame_engine #(.SAMPLE_W(SW), .LOG2_N(LN), .FFT_W(FW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .continuous    (continuous),
    .trig_mode     (trig_mode),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .scale_sel     (scale_sel),
    .avg_mode      (avg_mode),
    .clear_hold    (clear_hold),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .freq_valid    (freq_valid),
    .freq_addr     (freq_addr),
    .freq_byte     (freq_byte),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_tlast     (err_tlast)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge; inputs change at posedge+2.
  int          cyc = 0, cap_total = 0, stab_err = 0, s_cyc = 0, fd_total = 0, fd_cyc = 0;
  logic [15:0] cap_data [512];
  logic        cap_last [512];
  logic [7:0]  out_byte [16];
  logic [LN-1:0] fd_addr = '0;
  logic        fd_fv = 1'b0;
  logic        stall_q = 1'b0, stall_last = 1'b0;
  logic [15:0] stall_data = '0;

  always @(negedge aclk) begin
    cyc <= cyc + 1;
    if (m_axis_tvalid && m_axis_tready) begin
      cap_data[cap_total] <= m_axis_tdata;
      cap_last[cap_total] <= m_axis_tlast;
      cap_total <= cap_total + 1;
    end
    if (stall_q && (!m_axis_tvalid || m_axis_tdata != stall_data || m_axis_tlast != stall_last))
      stab_err <= stab_err + 1;
    stall_q    <= m_axis_tvalid && !m_axis_tready;
    stall_data <= m_axis_tdata;
    stall_last <= m_axis_tlast;
    if (s_axis_tvalid && s_axis_tready)
      s_cyc <= cyc;
    if (freq_valid)
      out_byte[freq_addr] <= freq_byte;
    if (frame_done) begin
      fd_total <= fd_total + 1;
      fd_addr  <= freq_addr;
      fd_fv    <= freq_valid;
      fd_cyc   <= cyc;
    end
  end

  logic [7:0]    smp [64];
  logic [FW-1:0] bin_re [16];
  logic [FW-1:0] bin_im [16];
  logic          rdy_rand = 1'b0;
  int            fbase;

  task automatic tick;
    @(posedge aclk);
    #2;
    if (rdy_rand) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_bins;
    for (int k = 0; k < N; k++) begin
      bin_re[k] = '0;
      bin_im[k] = '0;
    end
  endtask

  task automatic run_frame(input int nfeed, input int tlast_pos);
    int n;
    int fd0;
    fbase = cap_total;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_rise", busy, 1);
    for (int i = 0; i < nfeed; i++) begin
      sample_valid = 1'b1;
      sample_data  = smp[i];
      tick;
    end
    sample_valid = 1'b0;
    n = 0;
    while (cap_total < fbase + N && n < 400) begin tick; n++; end
    if (n == 400) check("load_timeout", cap_total - fbase, N);
    fd0 = fd_total;
    for (int k = 0; k < N; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {bin_im[k], bin_re[k]};
      s_axis_tlast  = (k == tlast_pos);
      n = 0;
      while (!s_axis_tready && n < 100) begin tick; n++; end
      tick;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n = 0;
    while (fd_total == fd0 && n < 50) begin tick; n++; end
    if (n == 50) check("done_timeout", fd_total - fd0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    aresetn = 1'b0; start = 1'b0; continuous = 1'b0; trig_mode = 1'b0;
    sample_valid = 1'b0; sample_data = '0; scale_sel = 3'd0; avg_mode = 2'b00;
    clear_hold = 1'b0; m_axis_tready = 1'b1; s_axis_tdata = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    clear_bins;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_freq_addr", freq_addr, 0);
    check("rst_freq_byte", freq_byte, 0);
    check("rst_err", err_tlast, 0);
    aresetn = 1'b1;
    tick;

    // Zero-crossing trigger; bin 3 re=im=2^16 gives P=2^33, window [34:27] -> 0x40
    trig_mode = 1'b1;
    smp[0] = 8'hFD; smp[1] = 8'hFF; smp[2] = 8'd2; smp[3] = 8'd5;
    for (int i = 4; i < 18; i++) smp[i] = 8'(i + 2);
    bin_re[3] = 18'd65536; bin_im[3] = 18'd65536;
    run_frame(18, 15);
    check("zc_addr0", cap_data[fbase], 16'h0002);
    check("zc_addr1", cap_data[fbase+1], 16'h0005);
    check("zc_addr15", cap_data[fbase+15], 16'h0013);
    nl = 0;
    for (int i = 0; i < N; i++) if (cap_last[fbase+i]) nl++;
    check("zc_tlast_count", nl, 1);
    check("zc_tlast_beat15", cap_last[fbase+15], 1);
    check("scale0_bin3", out_byte[3], 8'h40);
    check("scale0_bin0", out_byte[0], 8'h00);
    check("done_addr", fd_addr, 15);
    check("done_with_valid", fd_fv, 1);
    check("bin_latency", fd_cyc - s_cyc, 3);
    check("idle_after", busy, 0);
    check("no_err", err_tlast, 0);

    // Scale window: sel=1 -> 0x80, sel=7 -> saturate
    trig_mode = 1'b0;
    for (int i = 0; i < 64; i++) smp[i] = 8'(i + 1);
    scale_sel = 3'd1;
    run_frame(16, 15);
    check("scale1_bin3", out_byte[3], 8'h80);
    scale_sel = 3'd7;
    run_frame(16, 15);
    check("scale7_sat", out_byte[3], 8'hFF);
    check("free_addr0", cap_data[fbase], 16'h0001);

    // Auto-trigger: all-positive ramp, 17th valid sample triggers
    trig_mode = 1'b1;
    run_frame(40, 15);
    check("auto_addr0", cap_data[fbase], 16'h0011);
    check("auto_addr15", cap_data[fbase+15], 16'h0020);

    // Random backpressure on the FFT input
    trig_mode = 1'b0;
    for (int i = 0; i < N; i++) smp[i] = 8'(i - 8);
    rdy_rand = 1'b1;
    run_frame(16, 15);
    rdy_rand = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) check("bp_order", cap_data[fbase+i], {8'h00, smp[i]});
    check("bp_stable", stab_err, 0);
    check("bp_tlast", cap_last[fbase+15], 1);

    // Peak hold: (3072,1024) -> 10, (2048,0) -> 4 at scale 7
    for (int i = 0; i < N; i++) smp[i] = 8'(i + 1);
    clear_bins;
    avg_mode = 2'b01;
    bin_re[3] = 18'd3072; bin_im[3] = 18'd1024; bin_re[5] = 18'd2048;
    run_frame(16, 15);
    check("peak_a_bin3", out_byte[3], 8'd10);
    check("peak_a_bin5", out_byte[5], 8'd4);
    clear_bins;
    bin_re[3] = 18'd2048; bin_re[5] = 18'd3072; bin_im[5] = 18'd1024;
    run_frame(16, 15);
    check("peak_b_bin3", out_byte[3], 8'd10);
    check("peak_b_bin5", out_byte[5], 8'd10);

    // Average: mode change invalidates hold, then (10+4+1)>>1 = 7
    clear_bins;
    avg_mode = 2'b10;
    bin_re[3] = 18'd2048;
    run_frame(16, 15);
    check("avg_first_raw", out_byte[3], 8'd4);
    clear_bins;
    bin_re[3] = 18'd3072; bin_im[3] = 18'd1024;
    run_frame(16, 15);
    check("avg_mean", out_byte[3], 8'd7);
    clear_hold = 1'b1;
    tick;
    clear_hold = 1'b0;
    run_frame(16, 15);
    check("avg_after_clear", out_byte[3], 8'd10);

    // Early tlast on beat 7
    clear_bins;
    avg_mode = 2'b00;
    run_frame(16, 7);
    check("err_tlast_set", err_tlast, 1);
    check("err_done_addr", fd_addr, 15);

    // start clears the error; then reset while LOAD is stalled
    m_axis_tready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("err_clear", err_tlast, 0);
    for (int i = 0; i < N; i++) begin
      sample_valid = 1'b1;
      sample_data  = smp[i];
      tick;
    end
    sample_valid = 1'b0;
    nl = 0;
    while (!m_axis_tvalid && nl < 20) begin tick; nl++; end
    check("stall_tvalid", m_axis_tvalid, 1);
    aresetn = 1'b0;
    tick;
    check("abort_busy", busy, 0);
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_tdata", m_axis_tdata, 0);
    check("abort_tlast", m_axis_tlast, 0);
    check("abort_freq_valid", freq_valid, 0);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
